field_line_buffer: RTL and testbench
====================================

FIELD_LINE_BUFFER -- requirements
Module: field_line_buffer

Interface
REQ-001 Parameter H_ACTIVE, default 768: active pixels per line and buffer depth per bank.
REQ-002 Parameter DATA_W, default 16: pixel width (RGB565).
REQ-003 Parameter ADDR_W, default 10: bank address width; the block SHALL require 2^ADDR_W >= H_ACTIVE.
REQ-004 Port clk, input, 1: single clock for all logic; input and output timing share it.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port in_vs, input, 1: progressive vsync, active-high.
REQ-007 Port in_de, input, 1: progressive data enable.
REQ-008 Port in_data, input, DATA_W: progressive pixel, valid when in_de=1.
REQ-009 Port in_y, input, 12: progressive active-line index, stable while in_de=1.
REQ-010 Port field, input, 1: current interlaced field from the interlacer (0 = even lines, 1 = odd lines).
REQ-011 Port out_vs, out_hs, out_de, inputs, 1 each: interlaced timing from the interlacer.
REQ-012 Port vs_o, hs_o, de_o, outputs, 1 each: interlaced timing, delayed.
REQ-013 Port data_o, output, DATA_W: interlaced pixel aligned with de_o.
REQ-014 Port overflow, output, 1: sticky flag, line dropped because no bank was free.
REQ-015 Port underrun, output, 1: sticky flag, output line started with no full bank.

Function
REQ-016 Two banks (0, 1) of H_ACTIVE x DATA_W SHALL be held, each with a full flag and a stored pixel count wcnt (ADDR_W+1 bits).
REQ-017 Write FSM states: W_IDLE, W_CAP, W_SKIP; reset state W_IDLE, write bank pointer wb=0.
REQ-018 In W_IDLE, on the first in_de=1 cycle: if in_y[0]==field and bank wb is not full, go to W_CAP and write that pixel at address 0; otherwise go to W_SKIP.
REQ-019 In W_IDLE, if in_y[0]==field and bank wb is full, the block SHALL set overflow.
REQ-020 In W_CAP, each in_de=1 cycle SHALL write to the next address; pixels beyond H_ACTIVE SHALL be discarded.
REQ-021 On in_de falling in W_CAP, the block SHALL store wcnt = min(pixels received, H_ACTIVE), set full[wb], toggle wb, and return to W_IDLE.
REQ-022 On in_de falling in W_SKIP, the block SHALL return to W_IDLE with no bank change.
REQ-023 Read FSM states: R_IDLE, R_PLAY, R_BLANK; reset state R_IDLE, read bank pointer rb=0.
REQ-024 In R_IDLE, on the first out_de=1 cycle: if full[rb], go to R_PLAY with read address 0; otherwise set underrun and go to R_BLANK.
REQ-025 In R_PLAY, the read address SHALL increment each out_de=1 cycle; addresses >= wcnt[rb] SHALL yield data_o = 0.
REQ-026 On out_de falling in R_PLAY, the block SHALL clear full[rb], toggle rb, and return to R_IDLE.
REQ-027 In R_BLANK, data_o SHALL be 0 for the whole line; on out_de falling, return to R_IDLE with no bank change.
REQ-028 The first out_de edge at or after an out_vs rising edge SHALL NOT depend on in_vs; the two timing domains run free of each other.
REQ-029 vs_o, hs_o, de_o SHALL equal out_vs, out_hs, out_de delayed by exactly 2 clk cycles; data_o SHALL be registered and aligned with de_o.
REQ-030 data_o SHALL be 0 whenever de_o=0.
REQ-031 Simultaneous events: a set of full[wb] and a clear of full[rb] in the same cycle SHALL both take effect. If wb==rb, the write set SHALL win, which only happens when the bank was empty.
REQ-032 A rising edge of in_vs SHALL clear overflow and underrun.

Reset
REQ-033 While reset=1: vs_o, hs_o, de_o, overflow, underrun = 0; data_o = 0; both full flags = 0; wb = rb = 0; both FSMs idle.
REQ-034 Reset asserted mid-line SHALL abandon any capture or playback; bank RAM contents need not be cleared.
REQ-035 After reset deassertion, the first partial in_de or out_de line SHALL be ignored until the next rising edge of that signal.

Verification
REQ-036 field=0; input lines y=0,1,2 of 768 pixels with data=x; one 768-cycle out_de line -> data_o = 0..767 from line y=0, de_o 2 cycles after out_de, underrun = 0.
REQ-037 field=1, input y=0 -> W_SKIP with no write; input y=1 captured; the next output line replays y=1 data.
REQ-038 Capture 3 matching lines with no out_de -> third line dropped, overflow = 1, full = 2'b11; a later in_vs rising edge -> overflow = 0.
REQ-039 out_de line of 768 cycles with both banks empty -> underrun = 1, data_o = 0 for all 768 de_o cycles.
REQ-040 Short input line of 500 pixels -> output line data_o = stored pixels for 500 cycles, then 0 for 268 cycles.
REQ-041 Assert reset at pixel 300 of a capture and during playback -> all outputs 0 next cycle, full = 0, and the next full lines capture and play correctly.

Source files
------------

// File: rtl/field_line_buffer.sv
// field_line_buffer
//   Two-bank line store between a progressive source and an interlaced sink.
//   Progressive lines whose parity matches the current field are captured into
//   a free bank. Each interlaced output line replays the oldest full bank.
//   Input and output timing share one clock but are otherwise unrelated.
//   The bank address width must satisfy 2**ADDR_W >= H_ACTIVE.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   in_vs, in_de, in_data : progressive vsync / data enable / pixel
//   in_y                  : progressive active-line index (bit 0 selects field parity)
//   field                 : field being produced by the interlacer (0 even, 1 odd)
//   out_vs/out_hs/out_de  : interlaced timing from the interlacer
//   vs_o/hs_o/de_o        : interlaced timing delayed by two clocks
//   data_o                : interlaced pixel aligned with de_o, 0 outside de_o
//   overflow, underrun    : sticky error flags, cleared by a rising in_vs
module field_line_buffer #(
  parameter int H_ACTIVE = 768,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [DATA_W-1:0] in_data,
  input  logic [11:0]       in_y,
  input  logic              field,
  input  logic              out_vs,
  input  logic              out_hs,
  input  logic              out_de,
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [DATA_W-1:0] data_o,
  output logic              overflow,
  output logic              underrun
);

  typedef enum logic [1:0] {W_IDLE, W_CAP, W_SKIP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_PLAY, R_BLANK} r_state_t;

  localparam logic [ADDR_W:0] H_LEN = (ADDR_W + 1)'(H_ACTIVE);

  logic [DATA_W-1:0] mem [2][H_ACTIVE];

  w_state_t        w_state, w_next;
  r_state_t        r_state, r_next;
  logic            wb, rb;
  logic [1:0]      full, full_nx;
  logic [ADDR_W:0] wcnt [2];
  logic [ADDR_W:0] wpos, rpos;

  // Edge history registers come out of reset at 1 so a line already in
  // progress when reset is released is not mistaken for a new line.
  logic in_de_q, out_de_q, in_vs_q;
  logic in_rise, out_rise, vs_rise;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic              cap_start, set_full, ovf_set;
  logic [ADDR_W-1:0] ra;
  logic              rd_ok, play_start, clr_full, udr_set;

  logic              vs_p0, hs_p0, de_p0, vld_p0;
  logic [DATA_W-1:0] rdata_p0;

  logic unused_y;
  assign unused_y = ^in_y[11:1];

  assign in_rise  = in_de & ~in_de_q;
  assign out_rise = out_de & ~out_de_q;
  assign vs_rise  = in_vs & ~in_vs_q;

  // Write side: decide capture/skip at line start, count pixels, close bank.
  always_comb begin
    w_next    = w_state;
    we        = 1'b0;
    wa        = '0;
    cap_start = 1'b0;
    set_full  = 1'b0;
    ovf_set   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (in_rise) begin
          if ((in_y[0] == field) && !full[wb]) begin
            w_next    = W_CAP;
            we        = 1'b1;
            cap_start = 1'b1;
          end else begin
            w_next  = W_SKIP;
            ovf_set = (in_y[0] == field);
          end
        end
      end
      W_CAP: begin
        if (in_de) begin
          // Pixels past the bank depth are dropped; wpos saturates at H_LEN.
          if (wpos < H_LEN) begin
            we = 1'b1;
            wa = wpos[ADDR_W-1:0];
          end
        end else begin
          set_full = 1'b1;
          w_next   = W_IDLE;
        end
      end
      W_SKIP: begin
        if (!in_de) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read side: pick the bank at line start, play it or blank the line.
  always_comb begin
    r_next     = r_state;
    ra         = '0;
    rd_ok      = 1'b0;
    play_start = 1'b0;
    clr_full   = 1'b0;
    udr_set    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (out_rise) begin
          if (full[rb]) begin
            r_next     = R_PLAY;
            play_start = 1'b1;
            rd_ok      = (wcnt[rb] != '0);
          end else begin
            r_next  = R_BLANK;
            udr_set = 1'b1;
          end
        end
      end
      R_PLAY: begin
        if (out_de) begin
          // Beyond the stored count the line is padded with zeros.
          if (rpos < wcnt[rb]) begin
            rd_ok = 1'b1;
            ra    = rpos[ADDR_W-1:0];
          end
        end else begin
          clr_full = 1'b1;
          r_next   = R_IDLE;
        end
      end
      R_BLANK: begin
        if (!out_de) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // A same-cycle set and clear both apply; on the same bank the set wins.
  always_comb begin
    full_nx = full;
    if (clr_full) full_nx[rb] = 1'b0;
    if (set_full) full_nx[wb] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      wb      <= 1'b0;
      wpos    <= '0;
      wcnt[0] <= '0;
      wcnt[1] <= '0;
      in_de_q <= 1'b1;
    end else begin
      w_state <= w_next;
      in_de_q <= in_de;
      if (cap_start) begin
        wpos <= {{ADDR_W{1'b0}}, 1'b1};
      end else if ((w_state == W_CAP) && in_de && (wpos < H_LEN)) begin
        wpos <= wpos + 1'b1;
      end
      if (set_full) begin
        wcnt[wb] <= wpos;
        wb       <= ~wb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= R_IDLE;
      rb       <= 1'b0;
      rpos     <= '0;
      out_de_q <= 1'b1;
    end else begin
      r_state  <= r_next;
      out_de_q <= out_de;
      if (play_start) begin
        rpos <= {{ADDR_W{1'b0}}, 1'b1};
      end else if ((r_state == R_PLAY) && out_de && (rpos < H_LEN)) begin
        rpos <= rpos + 1'b1;
      end
      if (clr_full) rb <= ~rb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 2'b00;
      overflow <= 1'b0;
      underrun <= 1'b0;
      in_vs_q  <= 1'b0;
    end else begin
      full    <= full_nx;
      in_vs_q <= in_vs;
      if (vs_rise) begin
        overflow <= 1'b0;
        underrun <= 1'b0;
      end
      if (ovf_set) overflow <= 1'b1;
      if (udr_set) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wb][wa] <= in_data;
  end

  // Stage p0: timing sampled, bank read issued.
  always_ff @(posedge clk) begin
    rdata_p0 <= mem[rb][ra];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_p0  <= 1'b0;
      hs_p0  <= 1'b0;
      de_p0  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      vs_p0  <= out_vs;
      hs_p0  <= out_hs;
      de_p0  <= out_de;
      vld_p0 <= rd_ok;
    end
  end

  // Stage p1: registered outputs, data gated to zero outside valid pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_o   <= 1'b0;
      hs_o   <= 1'b0;
      de_o   <= 1'b0;
      data_o <= '0;
    end else begin
      vs_o   <= vs_p0;
      hs_o   <= hs_p0;
      de_o   <= de_p0;
      data_o <= (de_p0 && vld_p0) ? rdata_p0 : '0;
    end
  end

endmodule

// File: tb/tb_field_line_buffer.sv
module tb_field_line_buffer;

  localparam int H  = 768;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk;
  logic          reset;
  logic          in_vs, in_de, field;
  logic [DW-1:0] in_data;
  logic [11:0]   in_y;
  logic          out_vs, out_hs, out_de;
  logic          vs_o, hs_o, de_o;
  logic [DW-1:0] data_o;
  logic          overflow, underrun;

  field_line_buffer #(.H_ACTIVE(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_vs(in_vs), .in_de(in_de), .in_data(in_data), .in_y(in_y),
    .field(field),
    .out_vs(out_vs), .out_hs(out_hs), .out_de(out_de),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
    .overflow(overflow), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] sb[$];
  bit            mon_en = 1'b0;

  // Two-clock delay model of the interlaced timing.
  logic vs_d1, vs_d2, hs_d1, hs_d2, de_d1, de_d2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d1 <= 0; vs_d2 <= 0; hs_d1 <= 0; hs_d2 <= 0; de_d1 <= 0; de_d2 <= 0;
    end else begin
      vs_d1 <= out_vs; vs_d2 <= vs_d1;
      hs_d1 <= out_hs; hs_d2 <= hs_d1;
      de_d1 <= out_de; de_d2 <= de_d1;
    end
  end

  logic          e_vs, e_hs, e_de;
  logic [DW-1:0] e_data;
  always @(negedge clk) begin
    if (mon_en) begin
      e_vs = reset ? 1'b0 : vs_d2;
      e_hs = reset ? 1'b0 : hs_d2;
      e_de = reset ? 1'b0 : de_d2;
      n_checks++;
      if ({vs_o, hs_o, de_o} !== {e_vs, e_hs, e_de}) begin
        n_fail++;
        $display("FAIL timing_delay: vs/hs/de=%b%b%b expected %b%b%b at %0t",
                 vs_o, hs_o, de_o, e_vs, e_hs, e_de, $time);
      end
      if (de_o === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: de_o=1 data_o=%h with no expected pixel at %0t", data_o, $time);
        end else begin
          e_data = sb.pop_front();
          if (data_o !== e_data) begin
            n_fail++;
            $display("FAIL pixel: data_o=%h expected %h at %0t", data_o, e_data, $time);
          end
        end
      end else begin
        n_checks++;
        if (data_o !== '0) begin
          n_fail++;
          $display("FAIL data_idle: data_o=%h expected 0 while de_o=0 at %0t", data_o, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic in_line(input int y, input int n, input logic [DW-1:0] base);
    in_y = 12'(y);
    for (int x = 0; x < n; x++) begin
      in_de   = 1'b1;
      in_data = base + DW'(x);
      tick();
    end
    in_de   = 1'b0;
    in_data = '0;
    repeat (8) tick();
  endtask

  task automatic out_line(input int n, input bit with_vs);
    if (with_vs) begin
      out_vs = 1'b1; tick(); tick(); out_vs = 1'b0; tick();
    end
    out_hs = 1'b1; tick(); out_hs = 1'b0; tick(); tick();
    for (int i = 0; i < n; i++) begin
      out_de = 1'b1;
      tick();
    end
    out_de = 1'b0;
    repeat (6) tick();
  endtask

  task automatic in_vs_pulse();
    in_vs = 1'b1; tick(); tick(); in_vs = 1'b0; tick(); tick();
  endtask

  task automatic push_line(input logic [DW-1:0] base, input int stored);
    for (int x = 0; x < H; x++) sb.push_back((x < stored) ? base + DW'(x) : '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    n_checks++;
    if ({vs_o, hs_o, de_o, overflow, underrun} !== 5'b0 || data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: vs/hs/de/ovf/udr=%b%b%b%b%b data_o=%h expected all 0",
               vs_o, hs_o, de_o, overflow, underrun, data_o);
    end
    n_checks++;
    if (dut.full !== 2'b00 || dut.wb !== 1'b0 || dut.rb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: full=%b wb=%b rb=%b expected 00 0 0", dut.full, dut.wb, dut.rb);
    end
    n_checks++;
    if (dut.w_state !== 2'd0 || dut.r_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_fsm: w_state=%0d r_state=%0d expected 0 0", dut.w_state, dut.r_state);
    end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    field = 1'b0;
    in_line(0, H, 16'h0000);
    in_line(1, H, 16'h0400);
    in_line(2, H, 16'h0800);
    n_checks++;
    if (dut.full !== 2'b11 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_capture: full=%b overflow=%b expected 11 0", dut.full, overflow);
    end
    push_line(16'h0000, H);
    out_line(H, 1'b1);
    n_checks++;
    if (sb.size() != 0 || underrun !== 1'b0 || dut.full !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_play0: left=%0d underrun=%b full=%b expected 0 0 10", sb.size(), underrun, dut.full);
    end
    push_line(16'h0800, H);
    out_line(H, 1'b0);
    n_checks++;
    if (sb.size() != 0 || dut.full !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_play2: left=%0d full=%b expected 0 00", sb.size(), dut.full);
    end
  endtask

  task automatic test_field_odd();
    field = 1'b1;
    in_line(0, H, 16'h3000);
    n_checks++;
    if (dut.full !== 2'b00 || dut.mem[0][5] !== 16'h0005) begin
      n_fail++;
      $display("FAIL odd_skip: full=%b mem0[5]=%h expected 00 0005", dut.full, dut.mem[0][5]);
    end
    in_line(1, H, 16'h4000);
    n_checks++;
    if (dut.full !== 2'b01) begin
      n_fail++;
      $display("FAIL odd_capture: full=%b expected 01", dut.full);
    end
    push_line(16'h4000, H);
    out_line(H, 1'b1);
    n_checks++;
    if (sb.size() != 0 || dut.full !== 2'b00) begin
      n_fail++;
      $display("FAIL odd_play: left=%0d full=%b expected 0 00", sb.size(), dut.full);
    end
  endtask

  task automatic test_overflow();
    field = 1'b0;
    in_line(0, H, 16'h5000);
    in_line(2, H, 16'h6000);
    in_line(4, H, 16'h7000);
    n_checks++;
    if (dut.full !== 2'b11 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: full=%b overflow=%b expected 11 1", dut.full, overflow);
    end
    in_vs_pulse();
    n_checks++;
    if (overflow !== 1'b0 || dut.full !== 2'b11) begin
      n_fail++;
      $display("FAIL ovf_clear: overflow=%b full=%b expected 0 11", overflow, dut.full);
    end
    push_line(16'h5000, H);
    out_line(H, 1'b1);
    push_line(16'h6000, H);
    out_line(H, 1'b0);
    n_checks++;
    if (sb.size() != 0 || dut.full !== 2'b00) begin
      n_fail++;
      $display("FAIL ovf_drain: left=%0d full=%b expected 0 00", sb.size(), dut.full);
    end
  endtask

  task automatic test_underrun();
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL udr_pre: underrun=%b expected 0", underrun);
    end
    push_line(16'h0000, 0);
    out_line(H, 1'b1);
    n_checks++;
    if (underrun !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL udr_set: underrun=%b left=%0d expected 1 0", underrun, sb.size());
    end
    in_vs_pulse();
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL udr_clear: underrun=%b expected 0", underrun);
    end
  endtask

  task automatic test_short_long();
    field = 1'b0;
    in_line(0, 500, 16'h8000);
    push_line(16'h8000, 500);
    out_line(H, 1'b0);
    n_checks++;
    if (sb.size() != 0 || dut.full !== 2'b00) begin
      n_fail++;
      $display("FAIL short_line: left=%0d full=%b expected 0 00", sb.size(), dut.full);
    end
    in_line(2, 800, 16'h9000);
    push_line(16'h9000, H);
    out_line(H, 1'b0);
    n_checks++;
    if (sb.size() != 0 || dut.full !== 2'b00) begin
      n_fail++;
      $display("FAIL long_line: left=%0d full=%b expected 0 00", sb.size(), dut.full);
    end
  endtask

  task automatic test_reset_midline();
    field = 1'b0;
    in_line(0, H, 16'hB000);
    in_y = 12'd0;
    for (int x = 0; x < 300; x++) begin
      in_de = 1'b1; in_data = 16'hA000 + DW'(x); tick();
    end
    reset = 1'b1; in_de = 1'b0; in_data = '0;
    @(negedge clk);
    n_checks++;
    if (dut.full !== 2'b00 || dut.wb !== 1'b0 || dut.w_state !== 2'd0 || de_o !== 1'b0 || data_o !== '0) begin
      n_fail++;
      $display("FAIL rst_capture: full=%b wb=%b w_state=%0d de_o=%b data_o=%h expected 00 0 0 0 0",
               dut.full, dut.wb, dut.w_state, de_o, data_o);
    end
    tick(); tick();
    in_de = 1'b1; in_data = 16'hAAAA; tick();
    reset = 1'b0;
    repeat (100) tick();
    in_de = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (dut.full !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_partial: full=%b expected 00", dut.full);
    end
    in_line(0, H, 16'hC000);
    push_line(16'hC000, H);
    out_hs = 1'b1; tick(); out_hs = 1'b0; tick(); tick();
    for (int i = 0; i < 200; i++) begin
      out_de = 1'b1; tick();
    end
    reset = 1'b1; out_de = 1'b0;
    @(negedge clk);
    n_checks++;
    if (de_o !== 1'b0 || data_o !== '0 || dut.full !== 2'b00 || dut.rb !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_play: de_o=%b data_o=%h full=%b rb=%b expected 0 0 00 0",
               de_o, data_o, dut.full, dut.rb);
    end
    sb.delete();
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    in_line(0, H, 16'hD000);
    in_line(2, H, 16'hE000);
    push_line(16'hD000, H);
    out_line(H, 1'b1);
    push_line(16'hE000, H);
    out_line(H, 1'b0);
    n_checks++;
    if (sb.size() != 0 || dut.full !== 2'b00 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_recover: left=%0d full=%b underrun=%b expected 0 00 0", sb.size(), dut.full, underrun);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_vs = 1'b0; in_de = 1'b0; in_data = '0; in_y = '0; field = 1'b0;
    out_vs = 1'b0; out_hs = 1'b0; out_de = 1'b0;
    test_reset();
    test_basic();
    test_field_odd();
    test_overflow();
    test_underrun();
    test_short_long();
    test_reset_midline();
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
